// File: rtl/gate_controller_multi.sv
// Parking-lane gate controller: keypad PIN entry with attempt limit and timeout,
// tailgate detection and an occupancy counter that locks entry when the lot is full.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | gate closed, waiting for a vehicle at the entrance
// S_WAIT_PIN | vehicle present, waiting for a keypad attempt (timed)
// S_OPEN     | correct PIN given, gate open until the vehicle passes
// S_BLOCK    | lane locked after too many wrong PINs or a tailgate
module gate_controller_multi #(
  parameter int                  PW_WIDTH  = 8,
  parameter logic [PW_WIDTH-1:0] PASSWORD  = 8'h5A,
  parameter int                  MAX_TRIES = 3,
  parameter int                  TIMEOUT   = 16,
  parameter int                  CAPACITY  = 15,
  parameter int                  OCC_W     = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sensor_entrance,
  input  logic                sensor_exit,
  input  logic                vehicle_leave,
  input  logic [PW_WIDTH-1:0] input_password,
  input  logic                password_valid,
  output logic                gate_open,
  output logic                gate_close,
  output logic                alarm_wrong_pin,
  output logic                alarm_block,
  output logic [OCC_W-1:0]    occupancy,
  output logic                lot_full
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TRY_W-1:0] TRIES_LIMIT = TRY_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0] TIMER_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [OCC_W-1:0] OCC_CAP     = OCC_W'(CAPACITY);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_PIN = 2'd1,
    S_OPEN     = 2'd2,
    S_BLOCK    = 2'd3
  } state_t;

  state_t             r_state;
  logic [TMR_W-1:0]   r_timer;
  logic [TRY_W-1:0]   r_tries;
  logic               r_gate_open;
  logic               r_gate_close;
  logic               r_alarm_wrong;
  logic               r_alarm_block;
  logic [OCC_W-1:0]   r_occ;
  logic               r_lot_full;

  logic               w_pw_ok;
  logic               w_pw_bad;
  logic               w_occ_inc;
  logic [TRY_W-1:0]   w_tries_inc;
  logic [OCC_W-1:0]   w_occ_next;

  assign w_pw_ok     = password_valid && (input_password == PASSWORD);
  assign w_pw_bad    = password_valid && (input_password != PASSWORD);
  assign w_occ_inc   = (r_state == S_OPEN) && sensor_exit && !sensor_entrance;
  assign w_tries_inc = r_tries + TRY_W'(1);

  // A simultaneous entry and departure cancel out; both directions saturate.
  always_comb begin
    w_occ_next = r_occ;
    if (w_occ_inc && !vehicle_leave) begin
      if (r_occ != OCC_CAP) w_occ_next = r_occ + OCC_W'(1);
    end else if (vehicle_leave && !w_occ_inc) begin
      if (r_occ != '0) w_occ_next = r_occ - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_tries       <= '0;
      r_gate_open   <= 1'b0;
      r_gate_close  <= 1'b1;
      r_alarm_wrong <= 1'b0;
      r_alarm_block <= 1'b0;
      r_occ         <= '0;
      r_lot_full    <= 1'b0;
    end else begin
      r_occ      <= w_occ_next;
      r_lot_full <= (w_occ_next == OCC_CAP);

      case (r_state)
        S_IDLE: begin
          if (sensor_entrance && !r_lot_full) begin
            r_state <= S_WAIT_PIN;
            r_timer <= '0;
          end
        end

        // An attempt on the final timer cycle wins over the timeout.
        S_WAIT_PIN: begin
          if (w_pw_ok) begin
            r_state       <= S_OPEN;
            r_gate_open   <= 1'b1;
            r_gate_close  <= 1'b0;
            r_tries       <= '0;
            r_alarm_wrong <= 1'b0;
          end else if (w_pw_bad) begin
            r_tries       <= w_tries_inc;
            r_alarm_wrong <= 1'b1;
            r_timer       <= '0;
            if (w_tries_inc == TRIES_LIMIT) begin
              r_state       <= S_BLOCK;
              r_alarm_block <= 1'b1;
            end
          end else if (r_timer == TIMER_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        S_OPEN: begin
          if (sensor_exit) begin
            r_gate_open  <= 1'b0;
            r_gate_close <= 1'b1;
            if (sensor_entrance) begin
              r_state       <= S_BLOCK;
              r_alarm_block <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        S_BLOCK: begin
          if (w_pw_ok) begin
            r_state       <= S_IDLE;
            r_alarm_block <= 1'b0;
            r_alarm_wrong <= 1'b0;
            r_tries       <= '0;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_gate_open  <= 1'b0;
          r_gate_close <= 1'b1;
        end
      endcase
    end
  end

  assign gate_open       = r_gate_open;
  assign gate_close      = r_gate_close;
  assign alarm_wrong_pin = r_alarm_wrong;
  assign alarm_block     = r_alarm_block;
  assign occupancy       = r_occ;
  assign lot_full        = r_lot_full;

endmodule
